// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array drain path.
//   DATA_WIDTH_DEF / ARRAY_SIZE_DEF : default lane width and lane count
//   state_t                         : drain/deskew FSM state encoding
//   lane_lsb()                      : bit offset of a lane inside a packed row
package systolic_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ARRAY_SIZE_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Lane j of a packed row occupies bits [lane_lsb(j, w) +: w].
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sync_row_fifo.sv
// Synchronous single-clock FIFO holding whole rows.
//   clk, reset (async, active-low)
//   wr_en/wr_data : push a word; ignored when full unless a pop happens in the same cycle
//   rd_en         : pop the head word; ignored when empty
//   rd_data       : head word (stable until popped; zero after reset)
//   count         : current occupancy, 0..DEPTH
module sync_row_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_drain_deskew.sv
// Drains the bottom edge of the systolic array, removes the diagonal skew
// (column j of row r leaves the array j steps after column 0) and buffers
// whole rows for the writeback path.
//   clk, reset (async, active-low)
//   start, row_count         : begin a tile of row_count rows (ignored while busy)
//   col_data, col_valid      : bottom-edge lanes; col_valid marks one array step
//   out_data, out_last,
//   out_valid, out_ready     : deskewed row stream towards writeback
//   busy, done               : tile in progress / one-cycle completion pulse
//   array_hold               : tells the array controller to stop stepping
//   overflow_err             : sticky, a row was dropped on a full FIFO
//   state_dbg                : current FSM state
//
// Output handshake: a row moves when out_valid && out_ready at a rising edge;
// while out_valid=1 and out_ready=0, out_data/out_last hold their value and
// out_valid stays 1. out_valid never depends on out_ready.
module systolic_drain_deskew
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROWS_MAX   = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [$clog2(ROWS_MAX+1)-1:0]      row_count,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   col_data,
  input  logic                               col_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               array_hold,
  output logic                               overflow_err,
  output state_t                             state_dbg
);

  localparam int unsigned RW = $clog2(ROWS_MAX + 1);
  localparam int unsigned LW = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE) : 1;
  // Step on which FILL hands over to CAPTURE; unused when ARRAY_SIZE=1.
  localparam logic [SW-1:0] FILL_LAST = (ARRAY_SIZE >= 2) ? SW'(ARRAY_SIZE - 2) : '0;

  state_t         state_q;
  logic [SW-1:0]  step_q;
  logic [RW-1:0]  row_count_q;
  logic [RW-1:0]  rows_captured_q;
  logic [LW-1:0]  aligned;
  logic [LW:0]    fifo_rd;
  logic [CW-1:0]  fifo_count;
  logic           beat;
  logic           capture_beat;
  logic           last_row;
  logic           fifo_full;
  logic           pop;
  logic           push;
  logic           drop;
  logic           hold_next;

  // Array steps only count inside a tile; stray col_valid is ignored.
  assign beat         = col_valid && ((state_q == FILL) || (state_q == CAPTURE));
  assign capture_beat = col_valid && (state_q == CAPTURE);
  assign last_row     = (rows_captured_q + RW'(1)) == row_count_q;

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A simultaneous pop frees the slot, so only a truly full FIFO drops.
  assign push      = capture_beat && (!fifo_full || pop);
  assign drop      = capture_beat && fifo_full && !pop;
  // Two free entries cover the hold register plus the controller's own cycle.
  assign hold_next = (CW'(FIFO_DEPTH) - fifo_count) <= CW'(2);

  assign {out_last, out_data} = fifo_rd;
  assign state_dbg            = state_q;

  // Lane j is delayed by ARRAY_SIZE-1-j array steps so that on the beat of
  // step r+ARRAY_SIZE-1 every lane presents row r.
  genvar j;
  generate
    for (j = 0; j < ARRAY_SIZE - 1; j++) begin : g_lane
      localparam int unsigned TAPS = ARRAY_SIZE - 1 - j;
      logic [DATA_WIDTH-1:0] dly_q [TAPS];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < TAPS; k++) dly_q[k] <= '0;
        end else if (beat) begin
          dly_q[0] <= col_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
          for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
        end
      end

      assign aligned[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = dly_q[TAPS-1];
    end
  endgenerate

  assign aligned[lane_lsb(ARRAY_SIZE - 1, DATA_WIDTH) +: DATA_WIDTH] =
    col_data[lane_lsb(ARRAY_SIZE - 1, DATA_WIDTH) +: DATA_WIDTH];

  sync_row_fifo #(
    .WIDTH (LW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({last_row, aligned}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      step_q          <= '0;
      row_count_q     <= '0;
      rows_captured_q <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      array_hold      <= 1'b0;
      overflow_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      array_hold <= hold_next;
      if (drop) overflow_err <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            row_count_q     <= row_count;
            step_q          <= '0;
            rows_captured_q <= '0;
            if (row_count == '0) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              // A single-lane array has no skew to wait out.
              state_q <= (ARRAY_SIZE == 1) ? CAPTURE : FILL;
            end
          end
        end
        FILL: begin
          if (col_valid) begin
            step_q <= step_q + SW'(1);
            if (step_q == FILL_LAST) state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          // A dropped row still counts so the tile always terminates.
          if (col_valid) begin
            rows_captured_q <= rows_captured_q + RW'(1);
            if (last_row) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// Bench for systolic_drain_deskew with a 4x8-bit array and a 4-row FIFO.
// Lane value = 16*row + column. A scoreboard queue holds expected
// {last, row} words; a monitor pops and compares on every handshake.
module tb_systolic_drain_deskew;
  import systolic_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int RMAX  = 256;
  localparam int RCW   = $clog2(RMAX + 1);
  localparam int LW    = N * DW;
  localparam int FW    = LW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [RCW-1:0]  row_count;
  logic [LW-1:0]   col_data;
  logic            col_valid;
  logic [LW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            array_hold;
  logic            overflow_err;
  state_t          state_dbg;

  systolic_drain_deskew #(
    .ARRAY_SIZE (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ROWS_MAX   (RMAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .row_count    (row_count),
    .col_data     (col_data),
    .col_valid    (col_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .array_hold   (array_hold),
    .overflow_err (overflow_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int errors   = 0;
  int pops     = 0;
  int done_cnt = 0;
  logic [FW-1:0] exp_q[$];

  typedef struct {
    int rows;
    bit gapped;
    bit obey;
    int ready_delay;
    bit rand_ready;
    int extra_start;
    int exp_rows;
    bit exp_ovf;
    int exp_hold;   // -1 means not checked
  } vec_t;

  vec_t tbl[9];

  function automatic logic [LW-1:0] row_word(input int r);
    logic [LW-1:0] w;
    w = '0;
    for (int j = 0; j < N; j++) w[j*DW +: DW] = 8'(16 * r + j);
    return w;
  endfunction

  // Bottom-edge value on array step 'beat': lane j carries row beat-j.
  function automatic logic [LW-1:0] beat_word(input int beat, input int rows);
    logic [LW-1:0] w;
    int r;
    w = '0;
    for (int j = 0; j < N; j++) begin
      r = beat - j;
      w[j*DW +: DW] = (r >= 0 && r < rows) ? 8'(16 * r + j) : 8'hEE;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: sampled on the falling edge, away from the active edge.
  task automatic monitor();
    logic          stall;
    logic [FW-1:0] stall_word;
    logic [FW-1:0] exp;
    stall = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 1'b0;
      end else begin
        if (stall) check("hold_stable", {out_valid, out_last, out_data}, {1'b1, stall_word});
        if (out_valid && out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got 0x%0h, expected no row", {out_last, out_data});
          end else begin
            exp = exp_q.pop_front();
            check("row_data", {out_last, out_data}, exp);
          end
        end
        stall      = out_valid && !out_ready;
        stall_word = {out_last, out_data};
        if (done) done_cnt++;
      end
    end
  endtask

  // Drives one tile, modelling an array controller with one cycle of
  // reaction latency to array_hold (when obey=1).
  task automatic run_tile(input vec_t v);
    int cyc;
    int beats;
    int need;
    int pops0;
    int done0;
    bit hold_d;
    bit hold_seen;
    bit fin;
    for (int r = 0; r < v.exp_rows; r++) exp_q.push_back({1'(r == v.rows - 1), row_word(r)});
    pops0 = pops;
    done0 = done_cnt;
    start = 1'b1;
    row_count = RCW'(v.rows);
    col_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    beats = 0;
    need = v.rows + N - 1;
    hold_d = 1'b0;
    hold_seen = 1'b0;
    fin = 1'b0;
    for (cyc = 0; cyc < 300 && !fin; cyc++) begin
      start = (cyc == v.extra_start);
      if (start) row_count = RCW'(5);
      col_valid = (beats < need) && (!v.gapped || (cyc % 2 == 0)) && !(v.obey && hold_d);
      col_data  = beat_word(beats, v.rows);
      out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : (cyc >= v.ready_delay);
      hold_d = array_hold;
      tick();
      if (col_valid) beats++;
      hold_seen |= array_hold;
      fin = done;
    end
    start = 1'b0;
    col_valid = 1'b0;
    out_ready = 1'b1;
    check("tile_done", fin, 1);
    repeat (3) tick();
    check("rows_out", pops - pops0, v.exp_rows);
    check("sb_empty", exp_q.size(), 0);
    check("done_once", done_cnt - done0, 1);
    check("busy_clear", busy, 0);
    check("overflow_err", overflow_err, v.exp_ovf);
    if (v.exp_hold >= 0) check("hold_seen", hold_seen, v.exp_hold);
    exp_q.delete();
  endtask

  initial begin
    int  k;
    bit  seen;
    int  done0;
    vec_t one;

    tbl[0] = '{rows: 3, gapped: 0, obey: 1, ready_delay: 0,  rand_ready: 0, extra_start: -1, exp_rows: 3, exp_ovf: 0, exp_hold: 0};
    tbl[1] = '{rows: 6, gapped: 0, obey: 1, ready_delay: 30, rand_ready: 0, extra_start: -1, exp_rows: 6, exp_ovf: 0, exp_hold: 1};
    tbl[2] = '{rows: 3, gapped: 1, obey: 1, ready_delay: 0,  rand_ready: 0, extra_start: -1, exp_rows: 3, exp_ovf: 0, exp_hold: 0};
    tbl[3] = '{rows: 1, gapped: 0, obey: 1, ready_delay: 0,  rand_ready: 0, extra_start: -1, exp_rows: 1, exp_ovf: 0, exp_hold: 0};
    tbl[4] = '{rows: 2, gapped: 0, obey: 1, ready_delay: 0,  rand_ready: 0, extra_start: 2,  exp_rows: 2, exp_ovf: 0, exp_hold: 0};
    tbl[5] = '{rows: 5, gapped: 0, obey: 1, ready_delay: 0,  rand_ready: 1, extra_start: -1, exp_rows: 5, exp_ovf: 0, exp_hold: -1};
    tbl[6] = '{rows: 4, gapped: 1, obey: 1, ready_delay: 20, rand_ready: 0, extra_start: -1, exp_rows: 4, exp_ovf: 0, exp_hold: 1};
    tbl[7] = '{rows: 6, gapped: 0, obey: 0, ready_delay: 40, rand_ready: 0, extra_start: -1, exp_rows: 4, exp_ovf: 1, exp_hold: 1};
    tbl[8] = '{rows: 2, gapped: 0, obey: 1, ready_delay: 0,  rand_ready: 0, extra_start: -1, exp_rows: 2, exp_ovf: 1, exp_hold: 0};

    reset = 1'b0;
    start = 1'b0;
    row_count = '0;
    col_data = '0;
    col_valid = 1'b0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none

    // ---- reset values ----
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_array_hold", array_hold, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b1;
    tick();

    // ---- first-row latency: out_valid one cycle after the beat of step 3 ----
    for (int r = 0; r < 3; r++) exp_q.push_back({1'(r == 2), row_word(r)});
    done0 = done_cnt;
    start = 1'b1;
    row_count = RCW'(3);
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("lat_busy", busy, 1);
    for (int b = 0; b < 6; b++) begin
      col_valid = 1'b1;
      col_data  = beat_word(b, 3);
      tick();
      check("lat_valid", out_valid, (b >= 3) ? 1 : 0);
    end
    col_valid = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = done;
    end
    check("lat_done", seen, 1);
    tick();
    check("lat_busy_clear", busy, 0);
    check("lat_done_once", done_cnt - done0, 1);
    check("lat_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // ---- table of tiles ----
    for (int i = 0; i < 9; i++) run_tile(tbl[i]);

    // ---- stray col_valid in IDLE, then a zero-row tile ----
    for (int b = 0; b < 3; b++) begin
      col_valid = 1'b1;
      col_data  = beat_word(b, 4);
      tick();
    end
    col_valid = 1'b0;
    check("stray_state", state_dbg, IDLE);
    check("stray_out_valid", out_valid, 0);
    done0 = done_cnt;
    start = 1'b1;
    row_count = '0;
    tick();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_pulse", done, 0);
    check("zero_out_valid", out_valid, 0);
    check("zero_done_once", done_cnt - done0, 1);

    // ---- reset in the middle of CAPTURE ----
    for (int r = 0; r < 4; r++) exp_q.push_back({1'(r == 3), row_word(r)});
    start = 1'b1;
    row_count = RCW'(4);
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      col_valid = 1'b1;
      col_data  = beat_word(k, 4);
      tick();
      seen = out_valid;
    end
    check("mid_first_row", seen, 1);
    col_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_last", out_last, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_array_hold", array_hold, 0);
    check("mid_overflow", overflow_err, 0);
    check("mid_state", state_dbg, IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    one = '{rows: 1, gapped: 0, obey: 1, ready_delay: 0, rand_ready: 0, extra_start: -1, exp_rows: 1, exp_ovf: 0, exp_hold: 0};
    run_tile(one);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_drain_deskew.md
Name: systolic_drain_deskew

Overview:
- Drains result columns from the bottom boundary of the systolic PE array and removes the diagonal skew.
- Column j of row r leaves the array j array-steps after column 0, so the block realigns each row and buffers whole rows in a small FIFO.
- It presents the buffered rows downstream with a valid/ready handshake.
- It sits between the array's bottom-edge outputs and the result writeback path, and it gives the array controller backpressure (array_hold).

Parameters:
- ARRAY_SIZE, 128, number of columns (lanes).
- DATA_WIDTH, 8, bits per lane.
- FIFO_DEPTH, 4, rows buffered; must be at least 3.
- ROWS_MAX, 256, maximum rows per tile.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- reset, input, 1, asynchronous reset, active-low.
- start, input, 1, one-cycle pulse that begins a tile; ignored while busy=1.
- row_count, input, $clog2(ROWS_MAX+1), rows in the tile; sampled when start is accepted.
- col_data, input, ARRAY_SIZE*DATA_WIDTH, bottom-edge array outputs; lane j is bits [j*DW +: DW].
- col_valid, input, 1, the array advanced one step this cycle (mirrors the controller's mac_enable).
- out_data, output, ARRAY_SIZE*DATA_WIDTH, one deskewed row; lane j is column j.
- out_valid, output, 1, out_data holds a row.
- out_ready, input, 1, downstream accepts the row.
- out_last, output, 1, qualifies out_valid; marks the final row of the tile.
- busy, output, 1, a tile is in progress.
- done, output, 1, one-cycle pulse when the tile completes.
- array_hold, output, 1, the controller must drive col_valid=0 on the following cycles while this is 1.
- overflow_err, output, 1, sticky; set when a row was dropped.

Behaviour:
- Reset values: all outputs are 0, the FIFO is empty, the deskew registers are 0, and the FSM is in IDLE.
  - The asynchronous reset is active-low and may assert at any time; an in-flight tile is abandoned and nothing is emitted afterwards.
  - overflow_err clears only on reset.
- Step counter: counts col_valid beats after start, starting at 0. Column j carries row r on step r+j.
- Deskew:
  - Lane j passes through (ARRAY_SIZE-1-j) registers that shift only when col_valid=1. Lane ARRAY_SIZE-1 has no delay.
  - The aligned row r is available on the beat of step r+ARRAY_SIZE-1.
- FSM:
  - IDLE: on start, latch row_count and clear the step and row counters.
    - If row_count=0, pulse done on the next cycle and stay in IDLE.
    - Otherwise go to FILL and set busy=1.
  - FILL: count col_valid beats. On the beat of step ARRAY_SIZE-2, go to CAPTURE.
    - This transition must also occur when ARRAY_SIZE=1, i.e. go straight to CAPTURE.
  - CAPTURE: each col_valid beat pushes the aligned row into the FIFO and increments rows_captured.
    - The tag last = (rows_captured == row_count-1) is stored with the row.
    - After the last push, go to DRAIN.
  - DRAIN: when the FIFO is empty and no output handshake is pending, pulse done for one cycle, clear busy, and return to IDLE.
- Latency: with the FIFO empty, row r appears with out_valid=1 on the cycle after the beat of step r+ARRAY_SIZE-1.
- Output handshake:
  - A row transfers when out_valid and out_ready are both 1.
  - out_data and out_last must stay stable while out_valid=1 and out_ready=0.
  - If a push and a pop happen in the same cycle, the FIFO occupancy is unchanged.
- array_hold: a registered output, equal to 1 when free entries ≤ 2 on the previous cycle.
  - The 2-entry margin covers the one-cycle reaction latency of the controller.
- Overflow: a push while the FIFO is full drops the row and sets overflow_err.
  - rows_captured still increments, so the tile still terminates.
- Stray input: col_valid in IDLE or DRAIN is ignored.
- Start while busy: ignored; no state change.

Decomposition:
- Shared package systolic_pkg holds:
  - the DATA_WIDTH and ARRAY_SIZE defaults;
  - the FSM state enum (IDLE, FILL, CAPTURE, DRAIN);
  - the lane-slice helper macro/function.
- One sub-module, sync_row_fifo (width ARRAY_SIZE*DATA_WIDTH+1, depth FIFO_DEPTH), which exposes a count output.
- The deskew delay lines are a generate loop inside the top module.

Test Plan:
All scenarios use ARRAY_SIZE=4, DATA_WIDTH=8, FIFO_DEPTH=4, and lane value = 16*row + column, with col_valid held at 1 unless noted.
- Basic tile: start with row_count=3, out_ready=1.
  - Response: rows {0x00,0x01,0x02,0x03}, {0x10,…,0x13}, {0x20,…,0x23}, in order.
  - The first out_valid comes 1 cycle after step 3; out_last=1 only on row 2; done pulses once afterwards; busy returns to 0.
- Backpressure: row_count=6 with out_ready=0.
  - array_hold must rise once 2 rows are buffered.
  - The controller obeys and holds col_valid=0; after out_ready goes to 1, all 6 rows arrive intact and overflow_err stays 0.
- Overflow: row_count=6, out_ready=0, and the controller ignores array_hold.
  - Rows 4 and 5 are dropped, overflow_err=1, rows 0–3 are delivered, and done still pulses.
- Gapped col_valid: a 0/1 alternating pattern.
  - The output data is identical to the basic tile; only the timing stretches.
- Zero rows and start while busy:
  - start with row_count=0 gives a done pulse 1 cycle later and no out_valid.
  - A second start during a tile is ignored.
- Reset mid-CAPTURE: assert reset=0 after the first output row.
  - All outputs go to 0 immediately; after release, a fresh row_count=1 tile outputs {0x00,0x01,0x02,0x03}.
